// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for a 2**ADDR_W x DATA_W dual-port RAM with registered read.
// Converts push/pop into RAM strobes, tracks occupancy and qualifies read data.
module dpram_fifo_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AFULL_TH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic            pop_acc;
    logic            push_acc;

    // Flags come from the registered pointers only; the extra MSB separates full from empty.
    assign count       = wptr - rptr;
    assign empty       = (wptr == rptr);
    assign full        = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                         (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign almost_full = (count >= (ADDR_W+1)'(AFULL_TH));

    // Enables are held low while reset is asserted so the RAM sees no strobes.
    assign pop_acc  = rst_n && pop && !empty;
    assign push_acc = rst_n && push && (!full || pop_acc);

    assign ram_wr_en   = push_acc;
    assign ram_wr_addr = wptr[ADDR_W-1:0];
    assign ram_din     = push_data;
    assign ram_rd_en   = pop_acc;
    assign ram_rd_addr = rptr[ADDR_W-1:0];
    assign rd_data     = ram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) wptr <= wptr + 1'b1;
            if (pop_acc)  rptr <= rptr + 1'b1;
            rd_valid  <= pop_acc;
            overflow  <= push && full && !pop_acc;
            underflow <= pop && empty;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl: queue-based FIFO reference model plus a
// behavioural registered-read RAM; a monitor process checks the read stream.
module tb_dpram_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFULL = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_din;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_dout;

    dpram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AFULL)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_din(ram_din), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural 16x8 dual-port RAM, one-cycle registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
    end

    int unsigned   checks   = 0;
    int unsigned   failures = 0;
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];
    int unsigned   wcnt = 0;
    int unsigned   rcnt = 0;
    bit            exp_rv  = 0;
    bit            exp_ovf = 0;
    bit            exp_udf = 0;
    bit            mon_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst_n) begin
                chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
                chk("overflow", 32'(overflow), 32'(exp_ovf));
                chk("underflow", 32'(underflow), 32'(exp_udf));
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_unexpected", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", 32'(rd_data), 32'(e));
                    end
                end
            end
        end
    end

    task automatic check_flags();
        int unsigned sz = model_q.size();
        chk("count", 32'(count), sz);
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= AFULL));
    endtask

    // One clock cycle of stimulus; expectations are derived from the queue model.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit q);
        int unsigned sz;
        bit pa, wa;
        @(negedge clk);
        push = p; push_data = d; pop = q;
        #1;
        sz = model_q.size();
        check_flags();
        pa = q && (sz > 0);
        wa = p && ((sz < DEPTH) || pa);
        chk("ram_wr_en", 32'(ram_wr_en), 32'(wa));
        chk("ram_rd_en", 32'(ram_rd_en), 32'(pa));
        if (wa) begin
            chk("ram_wr_addr", 32'(ram_wr_addr), wcnt % DEPTH);
            chk("ram_din", 32'(ram_din), 32'(d));
        end
        if (pa) chk("ram_rd_addr", 32'(ram_rd_addr), rcnt % DEPTH);
        exp_rv  = pa;
        exp_ovf = p && (sz == DEPTH) && !pa;
        exp_udf = q && (sz == 0);
        if (pa) begin
            exp_q.push_back(model_q.pop_front());
            rcnt++;
        end
        if (wa) begin
            model_q.push_back(d);
            wcnt++;
        end
    endtask

    task automatic clear_model();
        model_q.delete();
        exp_q.delete();
        wcnt = 0; rcnt = 0;
        exp_rv = 0; exp_ovf = 0; exp_udf = 0;
    endtask

    task automatic check_reset_state();
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_afull", 32'(almost_full), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_underflow", 32'(underflow), 32'(0));
        chk("rst_wr_en", 32'(ram_wr_en), 32'(0));
        chk("rst_rd_en", 32'(ram_rd_en), 32'(0));
    endtask

    initial begin
        int unsigned pp, qp;
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        clear_model();
        #1;
        check_reset_state();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;

        // Fill from empty, then push while full.
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        step(1, 8'hAA, 0);
        step(0, 8'h00, 0);
        // Drain back-to-back, then pop while empty.
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Full with simultaneous push/pop, pointers wrapping.
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        for (int i = 0; i < 20; i++) step(1, 8'(8'h40 + i), 1);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Reset asserted mid-cycle with data in flight.
        for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0; push = 1'b0; pop = 1'b0;
        clear_model();
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h77, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Random traffic with bias phases to reach full and empty repeatedly.
        for (int ph = 0; ph < 6; ph++) begin
            pp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            qp = 100 - pp;
            for (int i = 0; i < 80; i++)
                step($urandom_range(99) < pp, 8'($urandom), $urandom_range(99) < qp);
        end
        while (model_q.size() != 0) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        @(posedge clk);
        #2;
        mon_en = 0;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
